// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with bounded locked bursts in front of a single-port data memory.
module dmem_arbiter #(
  parameter int MAX_LOCK = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid_0,
  output logic          req_ready_0,
  input  logic [AW-1:0] req_addr_0,
  input  logic [31:0]   req_wdata_0,
  input  logic [1:0]    req_wwidth_0,
  input  logic          req_lock_0,
  output logic          resp_valid_0,
  output logic [31:0]   resp_rdata_0,
  input  logic          req_valid_1,
  output logic          req_ready_1,
  input  logic [AW-1:0] req_addr_1,
  input  logic [31:0]   req_wdata_1,
  input  logic [1:0]    req_wwidth_1,
  input  logic          req_lock_1,
  output logic          resp_valid_1,
  output logic [31:0]   resp_rdata_1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [1:0]    mem_wwidth,
  input  logic [31:0]   mem_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW:0] MAXL = MAX_LOCK[CW:0];
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state_q;
  logic          owner_q, last_q;
  logic [CW-1:0] cnt_q;
  logic          g0, g1, lk;
  logic [CW:0]   n;
  always_comb begin
    g0 = state_q == LOCKED ? (!owner_q && req_valid_0) : (req_valid_0 && (!req_valid_1 || last_q));
    g1 = state_q == LOCKED ? (owner_q && req_valid_1) : (req_valid_1 && (!req_valid_0 || !last_q));
    lk = g1 ? req_lock_1 : req_lock_0;
    // count includes the transfer being accepted, so MAX_LOCK transfers fit in one burst
    n = (state_q == LOCKED ? {1'b0, cnt_q} : '0) + 1'b1;
    mem_addr   = g0 ? req_addr_0   : g1 ? req_addr_1   : '0;
    mem_wdata  = g0 ? req_wdata_0  : g1 ? req_wdata_1  : '0;
    mem_wwidth = g0 ? req_wwidth_0 : g1 ? req_wwidth_1 : '0;
  end
  assign req_ready_0 = g0;
  assign req_ready_1 = g1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      resp_rdata_0 <= '0;
      resp_rdata_1 <= '0;
    end else begin
      resp_valid_0 <= g0;
      resp_valid_1 <= g1;
      if (g0) resp_rdata_0 <= mem_rdata;
      if (g1) resp_rdata_1 <= mem_rdata;
      if (g0 || g1) begin
        last_q  <= g1;
        owner_q <= g1;
        if (lk && n < MAXL) begin
          state_q <= LOCKED;
          cnt_q   <= n[CW-1:0];
        end else begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end else if (state_q == LOCKED) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue scoreboard checked by an independent response monitor.
module tb_dmem_arbiter;
  logic        clk = 0, reset = 1;
  logic        req_valid_0 = 0, req_lock_0 = 0, req_valid_1 = 0, req_lock_1 = 0;
  logic [31:0] req_addr_0 = 0, req_wdata_0 = 0, req_addr_1 = 0, req_wdata_1 = 0;
  logic [1:0]  req_wwidth_0 = 0, req_wwidth_1 = 0;
  logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
  logic [31:0] resp_rdata_0, resp_rdata_1, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wwidth;
  logic [31:0] mem [0:255];
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q0[$], q1[$];
  int cyc_n = 0, n_checks = 0, n_fail = 0;

  dmem_arbiter #(.MAX_LOCK(4), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_addr_0(req_addr_0),
    .req_wdata_0(req_wdata_0), .req_wwidth_0(req_wwidth_0), .req_lock_0(req_lock_0),
    .resp_valid_0(resp_valid_0), .resp_rdata_0(resp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_addr_1(req_addr_1),
    .req_wdata_1(req_wdata_1), .req_wwidth_1(req_wwidth_1), .req_lock_1(req_lock_1),
    .resp_valid_1(resp_valid_1), .resp_rdata_1(resp_rdata_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wwidth(mem_wwidth), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_wwidth == 2'd1) mem[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
    else if (mem_wwidth == 2'd2) mem[mem_addr[7:0]][15:0] <= mem_wdata[15:0];
    else if (mem_wwidth == 2'd3) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    int   sz;
    sz = p == 0 ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) check(p == 0 ? "unexpected_resp_0" : "unexpected_resp_1", 32'd1, 32'd0);
      else begin
        e = p == 0 ? q0.pop_front() : q1.pop_front();
        check(p == 0 ? "resp_rdata_0" : "resp_rdata_1", d, e.d);
        check(p == 0 ? "resp_latency_0" : "resp_latency_1", cyc_n, e.c + 1);
      end
    end
    sz = p == 0 ? q0.size() : q1.size();
    if (sz > 0) begin
      e = p == 0 ? q0[0] : q1[0];
      if (e.c < cyc_n - 1) begin
        check(p == 0 ? "missing_resp_0" : "missing_resp_1", 32'd0, 32'd1);
        if (p == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, resp_valid_0, resp_rdata_0);
    mon(1, resp_valid_1, resp_rdata_1);
  end

  task automatic cyc(input logic rst,
                     input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic [1:0] w0, input logic l0,
                     input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] w1, input logic l1,
                     input logic eg0, input logic eg1, input logic [31:0] er0, input logic [31:0] er1);
    exp_t e;
    reset = rst;
    req_valid_0 = v0; req_addr_0 = a0; req_wdata_0 = d0; req_wwidth_0 = w0; req_lock_0 = l0;
    req_valid_1 = v1; req_addr_1 = a1; req_wdata_1 = d1; req_wwidth_1 = w1; req_lock_1 = l1;
    @(negedge clk);
    check("ready_0", {31'd0, req_ready_0}, {31'd0, eg0});
    check("ready_1", {31'd0, req_ready_1}, {31'd0, eg1});
    check("mem_addr", mem_addr, eg0 ? a0 : eg1 ? a1 : 32'd0);
    check("mem_wwidth", {30'd0, mem_wwidth}, {30'd0, eg0 ? w0 : eg1 ? w1 : 2'd0});
    if (!rst && eg0) begin e.d = er0; e.c = cyc_n; q0.push_back(e); end
    if (!rst && eg1) begin e.d = er1; e.c = cyc_n; q1.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4{i[7:0]}};
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344;
    idle(1);
    idle(1);
    @(negedge clk);
    check("reset_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    check("reset_rdata_0", resp_rdata_0, 32'd0);
    check("reset_rdata_1", resp_rdata_1, 32'd0);
    @(posedge clk);
    #1;
    // round-robin contention right after reset: 0,1,0,1
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 32'h30, 0, 0, 0, 1, 32'h31, 0, 0, 0, i % 2 == 0, i % 2 == 1, 32'h30303030, 32'h31313131);
    idle(0);
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h20, 32'hAABBCCDD, 2'd1, 0, 0, 1, 0, 32'h11223344);
    cyc(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h112233DD, 0);
    // last grant is port 0, so locking port 1 wins, holds 4 transfers, then yields
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 32'h30, 0, 0, 0, 1, 32'h31, 0, 0, 1, 0, 1, 0, 32'h31313131);
    cyc(0, 1, 32'h30, 0, 0, 0, 1, 32'h31, 0, 0, 1, 1, 0, 32'h30303030, 0);
    idle(0);
    cyc(0, 1, 32'h40, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h40404040, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h41, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h41, 0, 0, 0, 0, 1, 0, 32'h41414141);
    idle(0);
    cyc(0, 1, 32'h50, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h50505050, 0);
    cyc(1, 1, 32'h51, 0, 0, 1, 1, 32'h52, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 32'h53, 0, 0, 0, 1, 32'h54, 0, 0, 0, 1, 0, 32'h53535353, 0);
    cyc(0, 1, 32'h53, 0, 0, 0, 1, 32'h54, 0, 0, 0, 0, 1, 0, 32'h54545454);
    idle(0);
    idle(0);
    check("queue_0_drained", q0.size(), 32'd0);
    check("queue_1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
